clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel programmable clock divider and tick generator: the parametrised successor of the single fixed-ratio divider. It derives CHANNELS independent slow strobes from the 1 MHz system clock, each with a runtime divisor, enable, and output mode (50 % toggle or one-cycle pulse). Divisor updates are glitch-free and a global sync realigns all channels. It feeds display scanning, debounce sampling and the single-step CPU clock.

## Interface
- CHANNELS, 4, number of independent divider channels (1–16)
- WIDTH, 32, divisor/counter width in bits
- DEFAULT_DIV, 499, divisor loaded at reset (toggle mode at 1 MHz gives 1 kHz)

- clk_1M  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- en  in  CHANNELS  per-channel run enable
- mode  in  CHANNELS  per-channel output mode: 0 = toggle (50 % duty), 1 = pulse
- div_in  in  CHANNELS*WIDTH  new divisor; channel i uses bits [i*WIDTH +: WIDTH]
- load  in  CHANNELS  per-channel strobe: capture div_in slice as pending divisor
- sync  in  1  synchronous restart of all channels
- clk_out  out  CHANNELS  divided clock (toggle) or strobe (pulse), registered
- tick  out  CHANNELS  one-cycle strobe at every terminal count, registered

## Operation
- Per channel: active divisor D, shadow S, pending flag P, counter C, registered mode_q.
- Terminal count (TC) is C == D while en=1. On TC: C←0, tick←1; mode 0 toggles clk_out; mode 1 sets clk_out←1 for that one cycle. Otherwise, with en=1: C←C+1, tick←0, and clk_out←0 in mode 1.
- Periods: tick, and clk_out in pulse mode, recur every D+1 cycles. clk_out in toggle mode has a period of 2(D+1) cycles at exactly 50 % duty.
- load[i]=1: S←div_in slice, P←1. A later load before TC overwrites S; the last value wins.
- Pending apply: at TC, if P=1 then D←S and P←0. The new D governs the next period, so no period is truncated or stretched mid-count.
- load coincident with TC: div_in is applied directly to D at that TC, and P is left 0.
- en=0: C holds, tick=0. In mode 0 clk_out holds its level; in mode 1 clk_out=0. Any pending S is applied to D on the next cycle and P is cleared. Re-enable resumes counting from the held C.
- Mode change (mode≠mode_q): C←0, clk_out←0, tick←0, mode_q←mode. The channel then counts from zero in the new mode.
- sync=1: every channel takes C←0, clk_out←0, tick←0, and applies a pending S (D←S, P←0). After sync, all enabled channels with equal D are phase-aligned.
- Priority: reset > sync > mode change > en/TC logic.
- D=0: mode 0 toggles every cycle (period 2); mode 1 holds clk_out=1 and tick=1 continuously.
- The counter never exceeds D. If D is lowered below C through the en=0 immediate-apply path, C←0 on the same edge.

## Timing
- Reset values (asynchronous): C=0, clk_out=0, tick=0, D=S=DEFAULT_DIV, P=0, mode_q=0.
- After reset release, or after asserting en with C=0, the first TC occurs on the (D+1)-th rising edge. tick and clk_out change on that edge.
- Every output comes directly from a flop; there are no combinational paths from inputs to outputs.
- load, en, mode and sync are sampled on each rising edge, with one-cycle effect latency.
- Reset asserted mid-period forces the reset values immediately, regardless of the clock.

## Test plan
- Reset release with en=4'b0001, mode=0, D=499 → clk_out[0] rises at edge 500, falls at edge 1000, period 1000; tick[0] is high for 1 cycle every 500 cycles.
- Channel 1 in mode 1 with load div_in=3 while en=0, then en=1 → clk_out[1] and tick[1] pulse on edges 4, 8, 12, … with each pulse exactly 1 cycle wide.
- Channel 0 running D=9, load 4 at C=5 → the current period completes at 10 cycles and the next periods are 5 cycles. Repeat with load on the TC cycle → the new period starts immediately.
- D=0 in mode 0 → clk_out toggles every edge. Switch to mode 1 → clk_out=0 and tick=0 for one cycle, then both are held at 1.
- Channels 0 and 2 at D=7 with offset phases, pulse sync → both are 0 the next cycle, then produce coincident ticks every 8 cycles.
- Assert reset mid-count with clk_out=1 → all outputs go to 0 with no clock edge. After release, D returns to 499.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent programmable dividers, each producing a divided clock and a terminal-count tick
module clk_div_bank #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 499
) (
    input  logic                      clk_1M,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] div_in,
    input  logic [CHANNELS-1:0]       load,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick
);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_div, r_shd, r_cnt;
        logic [WIDTH-1:0] w_div, w_shd, w_cnt, w_slice;
        logic             r_pend, r_mode, r_clk, r_tick;
        logic             w_pend, w_mode, w_clk, w_tick, w_tc;

        assign w_slice = div_in[i*WIDTH +: WIDTH];
        assign w_tc    = en[i] && (r_cnt >= r_div);

        // Next state in priority order: sync, mode change, terminal count, counting, idle
        always_comb begin
            w_div  = r_div;
            w_shd  = load[i] ? w_slice : r_shd;
            w_pend = r_pend | load[i];
            w_cnt  = r_cnt;
            w_mode = r_mode;
            w_clk  = r_clk;
            w_tick = 1'b0;
            if (sync) begin
                w_cnt  = '0;
                w_clk  = 1'b0;
                w_mode = mode[i];
                w_div  = r_pend ? r_shd : r_div;
                w_pend = load[i];
            end else if (mode[i] != r_mode) begin
                w_cnt  = '0;
                w_clk  = 1'b0;
                w_mode = mode[i];
            end else if (w_tc) begin
                w_cnt  = '0;
                w_tick = 1'b1;
                w_clk  = r_mode | ~r_clk;
                w_div  = load[i] ? w_slice : (r_pend ? r_shd : r_div);
                w_pend = 1'b0;
            end else if (en[i]) begin
                w_cnt = r_cnt + 1'b1;
                w_clk = r_clk & ~r_mode;
            end else begin
                w_clk = r_clk & ~r_mode;
                if (r_pend) begin
                    w_div  = r_shd;
                    w_pend = load[i];
                    w_cnt  = (r_shd < r_cnt) ? '0 : r_cnt;
                end
            end
        end

        // Channel state registers, cleared asynchronously
        always_ff @(posedge clk_1M or negedge reset) begin
            if (!reset) begin
                r_div  <= DEF;
                r_shd  <= DEF;
                r_pend <= 1'b0;
                r_cnt  <= '0;
                r_mode <= 1'b0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_div  <= w_div;
                r_shd  <= w_shd;
                r_pend <= w_pend;
                r_cnt  <= w_cnt;
                r_mode <= w_mode;
                r_clk  <= w_clk;
                r_tick <= w_tick;
            end
        end

        assign clk_out[i] = r_clk;
        assign tick[i]    = r_tick;
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed and random stimulus against a per-channel behavioural model
`timescale 1ns/1ps
module tb_clk_div_bank;
    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk_1M = 1'b0;
    logic            reset;
    logic [CH-1:0]   en, mode, load;
    logic [CH*W-1:0] div_in;
    logic            sync;
    logic [CH-1:0]   clk_out, tick;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] md[CH], ms[CH], mc[CH];
    logic        mp[CH], mq[CH], mo[CH], mt[CH];

    clk_div_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(499)) dut (
        .clk_1M (clk_1M),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .div_in (div_in),
        .load   (load),
        .sync   (sync),
        .clk_out(clk_out),
        .tick   (tick)
    );

    always #500 clk_1M = ~clk_1M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            md[c] = 499; ms[c] = 499; mc[c] = 0;
            mp[c] = 0; mq[c] = 0; mo[c] = 0; mt[c] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            logic [31:0] dv = div_in[c*W +: W];
            logic        ld = load[c];
            if (sync) begin
                if (mp[c]) begin md[c] = ms[c]; mp[c] = 0; end
                mc[c] = 0; mo[c] = 0; mt[c] = 0; mq[c] = mode[c];
            end else if (mode[c] != mq[c]) begin
                mc[c] = 0; mo[c] = 0; mt[c] = 0; mq[c] = mode[c];
            end else if (en[c]) begin
                if (mc[c] == md[c]) begin
                    mc[c] = 0; mt[c] = 1;
                    mo[c] = mode[c] ? 1'b1 : !mo[c];
                    if (ld) begin md[c] = dv; ms[c] = dv; mp[c] = 0; ld = 0; end
                    else if (mp[c]) begin md[c] = ms[c]; mp[c] = 0; end
                end else begin
                    mc[c] = mc[c] + 1; mt[c] = 0;
                    if (mode[c]) mo[c] = 0;
                end
            end else begin
                mt[c] = 0;
                if (mode[c]) mo[c] = 0;
                if (mp[c]) begin md[c] = ms[c]; mp[c] = 0; end
                if (mc[c] > md[c]) mc[c] = 0;
            end
            if (ld) begin ms[c] = dv; mp[c] = 1; end
        end
    endfunction

    function automatic logic [CH-1:0] m_clk();
        for (int c = 0; c < CH; c++) m_clk[c] = mo[c];
    endfunction

    function automatic logic [CH-1:0] m_tick();
        for (int c = 0; c < CH; c++) m_tick[c] = mt[c];
    endfunction

    task automatic cyc();
        @(posedge clk_1M);
        model_step();
        #1;
        check("model_clk_out", 32'(clk_out), 32'(m_clk()));
        check("model_tick", 32'(tick), 32'(m_tick()));
    endtask

    task automatic set_div(input int c, input logic [31:0] v);
        div_in[c*W +: W] = v;
    endtask

    initial begin
        reset = 1'b0; en = '0; mode = '0; load = '0; div_in = '0; sync = 1'b0;
        model_reset();
        #1700;
        check("reset_clk_out", 32'(clk_out), 0);
        check("reset_tick", 32'(tick), 0);
        @(negedge clk_1M);
        reset = 1'b1; en = 4'b0001;

        for (int e = 1; e <= 1000; e++) begin
            cyc();
            if (e == 499 || e == 500 || e == 501 || e == 999 || e == 1000) begin
                check("t1_clk0", 32'(clk_out[0]), 32'(e >= 500 && e < 1000));
                check("t1_tick0", 32'(tick[0]), 32'(e == 500 || e == 1000));
            end
        end

        en = '0; mode = 4'b0010; load = 4'b0010; set_div(1, 3);
        cyc();
        load = '0;
        cyc();
        en = 4'b0010;
        for (int e = 1; e <= 16; e++) begin
            cyc();
            check("t2_clk1", 32'(clk_out[1]), 32'(e % 4 == 0));
            check("t2_tick1", 32'(tick[1]), 32'(e % 4 == 0));
        end

        en = '0; load = 4'b0001; set_div(0, 9);
        cyc();
        load = '0;
        cyc();
        en = 4'b0001;
        for (int e = 1; e <= 31; e++) begin
            load = '0;
            if (e == 6) begin load = 4'b0001; set_div(0, 4); end
            if (e == 25) begin load = 4'b0001; set_div(0, 2); end
            cyc();
            check("t3_tick0", 32'(tick[0]), 32'(e == 10 || e == 15 || e == 20 || e == 25 || e == 28 || e == 31));
        end
        load = '0;

        en = '0; load = 4'b0001; set_div(0, 0);
        cyc();
        load = '0;
        cyc();
        en = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            cyc();
            check("t4_toggle", 32'(clk_out[0]), 32'(e % 2));
        end
        mode = 4'b0011;
        cyc();
        check("t4_sw_clk", 32'(clk_out[0]), 0);
        check("t4_sw_tick", 32'(tick[0]), 0);
        for (int e = 1; e <= 3; e++) begin
            cyc();
            check("t4_hold_clk", 32'(clk_out[0]), 1);
            check("t4_hold_tick", 32'(tick[0]), 1);
        end

        mode = '0; en = '0; load = 4'b0101; set_div(0, 7); set_div(2, 7);
        cyc();
        load = '0;
        cyc();
        en = 4'b0001;
        repeat (3) cyc();
        en = 4'b0101;
        repeat (5) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("t5_sync_clk", 32'({clk_out[2], clk_out[0]}), 0);
        check("t5_sync_tick", 32'({tick[2], tick[0]}), 0);
        for (int e = 1; e <= 24; e++) begin
            cyc();
            check("t5_tick0", 32'(tick[0]), 32'(e % 8 == 0));
            check("t5_tick2", 32'(tick[2]), 32'(e % 8 == 0));
        end

        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                en[c] = ($urandom_range(0, 7) != 0);
                load[c] = ($urandom_range(0, 15) == 0);
                set_div(c, $urandom_range(0, 12));
                if ($urandom_range(0, 199) == 0) mode[c] = ~mode[c];
            end
            sync = ($urandom_range(0, 63) == 0);
            cyc();
        end

        sync = 1'b0; mode = '0; en = 4'b1111; load = 4'b0001; set_div(0, 5);
        cyc();
        load = '0;
        for (int n = 0; n < 50 && !clk_out[0]; n++) cyc();
        check("t7_pre_clk0", 32'(clk_out[0]), 1);
        @(negedge clk_1M);
        #100;
        reset = 1'b0;
        model_reset();
        #1;
        check("t7_async_clk", 32'(clk_out), 0);
        check("t7_async_tick", 32'(tick), 0);
        @(negedge clk_1M);
        reset = 1'b1; en = 4'b0001;
        for (int e = 1; e <= 500; e++) begin
            cyc();
            if (e >= 499) check("t7_tick0_default", 32'(tick[0]), 32'(e == 500));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
